// File: rtl/tmr_opgroup_pipe.sv
// Elastic register pipeline for one TMR operation group, with a checker that watches output
// IDs and flags a copy sequence that breaks before three matching copies have passed.
module tmr_opgroup_pipe #(
  parameter type         DataType = logic [7:0],
  parameter int unsigned IDSize   = 5,
  parameter int unsigned NumRegs  = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  input  logic                           flush_i,
  input  DataType                        data_i,
  input  logic [IDSize-1:0]              id_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output DataType                        data_o,
  output logic [IDSize-1:0]              id_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [$clog2(NumRegs+1)-1:0]   occupancy_o,
  output logic                           id_error_o
);

  localparam int unsigned OccW = $clog2(NumRegs + 1);

  // Index i of the *_q arrays holds stage i+1; index i of the *_s arrays is what feeds it.
  logic [NumRegs-1:0] valid_q, valid_d;
  logic [NumRegs-1:0] valid_s;
  logic [NumRegs-1:0] ready;
  logic [NumRegs-1:0] load;
  DataType            data_q [NumRegs];
  DataType            data_s [NumRegs];
  logic [IDSize-1:0]  id_q   [NumRegs];
  logic [IDSize-1:0]  id_s   [NumRegs];

  always_comb begin
    valid_s   = '0;
    valid_s[0] = valid_i;
    data_s[0] = data_i;
    id_s[0]   = id_i;
    for (int i = 1; i < NumRegs; i++) begin
      valid_s[i] = valid_q[i-1];
      data_s[i]  = data_q[i-1];
      id_s[i]    = id_q[i-1];
    end
  end

  // A stage can accept when downstream is ready or any later stage holds a bubble.
  always_comb begin
    ready = '0;
    for (int i = 0; i < NumRegs; i++) begin
      ready[i] = ready_i;
      for (int j = i; j < NumRegs; j++) begin
        if (!valid_q[j]) begin
          ready[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    load    = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (ready[i]) begin
        valid_d[i] = valid_s[i];
      end
      load[i] = ready[i] & valid_s[i] & ~flush_i;
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NumRegs; i++) begin
        if (load[i]) begin
          data_q[i] <= data_s[i];
          id_q[i]   <= id_s[i];
        end
      end
    end
  end

  assign ready_o = ready[0] | flush_i;
  assign valid_o = valid_q[NumRegs-1];
  assign data_o  = data_q[NumRegs-1];
  assign id_o    = id_q[NumRegs-1];

  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < NumRegs; i++) begin
      occupancy_o = occupancy_o + OccW'(valid_q[i]);
    end
  end

  logic [1:0]        cnt_q, cnt_d;
  logic [IDSize-1:0] last_id_q, last_id_d;
  logic              err_q, err_d;
  logic              out_hs;

  assign out_hs = valid_o & ready_i;

  // cnt counts copies of last_id seen so far; a third copy closes the group.
  always_comb begin
    cnt_d     = cnt_q;
    last_id_d = last_id_q;
    err_d     = 1'b0;
    if (!enable_i || flush_i) begin
      cnt_d = 2'd0;
    end else if (out_hs) begin
      if (cnt_q == 2'd0) begin
        last_id_d = id_o;
        cnt_d     = 2'd1;
      end else if (id_o == last_id_q) begin
        cnt_d = (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
      end else begin
        err_d     = 1'b1;
        last_id_d = id_o;
        cnt_d     = 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= 2'd0;
      last_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      last_id_q <= last_id_d;
      err_q     <= err_d;
    end
  end

  assign id_error_o = err_q;

endmodule

// File: tb/tb_tmr_opgroup_pipe.sv
// Bench for tmr_opgroup_pipe at default parameters: a per-cycle vector table for streaming,
// backpressure, bubble collapse and flush, then hand sequences for the ID checker and reset.
module tb_tmr_opgroup_pipe;

  logic       clk_i      = 1'b0;
  logic       rst_i      = 1'b1;
  logic       enable_i   = 1'b0;
  logic       flush_i    = 1'b0;
  logic [7:0] data_i     = '0;
  logic [4:0] id_i       = '0;
  logic       valid_i    = 1'b0;
  logic       ready_i    = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic [4:0] id_o;
  logic       valid_o;
  logic [1:0] occupancy_o;
  logic       id_error_o;

  int n_checks = 0;
  int n_fail   = 0;

  tmr_opgroup_pipe dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .flush_i     (flush_i),
    .data_i      (data_i),
    .id_i        (id_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .id_o        (id_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .occupancy_o (occupancy_o),
    .id_error_o  (id_error_o)
  );

  always #5 clk_i = ~clk_i;

  // Error-pulse monitor, sampled mid-cycle.
  int cyc        = 0;
  int err_pulses = 0;
  int err_cyc    = -1;
  int hs9_cyc    = -1;
  always @(negedge clk_i) begin
    #2;
    cyc++;
    if (id_error_o) begin
      err_pulses++;
      err_cyc = cyc;
    end
    if (valid_o && ready_i && id_o == 5'd9 && hs9_cyc < 0) hs9_cyc = cyc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " valid_o"}, valid_o, 0);
    check({tag, " data_o"}, data_o, 0);
    check({tag, " id_o"}, id_o, 0);
    check({tag, " occupancy_o"}, occupancy_o, 0);
    check({tag, " id_error_o"}, id_error_o, 0);
    check({tag, " ready_o"}, ready_o, 1);
  endtask

  typedef struct {
    logic       vi;
    logic [7:0] d;
    logic       ri;
    logic       fl;
    logic       evo;
    logic       chkd;
    logic [7:0] ed;
    logic [1:0] eocc;
    logic       ero;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vi, input logic [7:0] d, input logic ri, input logic fl,
                     input logic evo, input logic chkd, input logic [7:0] ed,
                     input logic [1:0] eocc, input logic ero);
    vec_t v;
    v.vi = vi; v.d = d; v.ri = ri; v.fl = fl;
    v.evo = evo; v.chkd = chkd; v.ed = ed; v.eocc = eocc; v.ero = ero;
    vecs.push_back(v);
  endtask

  task automatic send(input logic [4:0] id, input logic [7:0] d);
    @(negedge clk_i);
    valid_i = 1'b1;
    id_i    = id;
    data_i  = d;
    flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      flush_i = 1'b0;
    end
  endtask

  int e0;

  initial begin
    // Streaming: three beats, valid_o from the fourth cycle on.
    add(1, 8'h11, 1, 0,  0, 0, 8'h00, 0, 1);
    add(1, 8'h22, 1, 0,  0, 0, 8'h00, 1, 1);
    add(1, 8'h33, 1, 0,  0, 0, 8'h00, 2, 1);
    add(1, 8'h44, 1, 0,  1, 1, 8'h11, 3, 1);
    add(1, 8'h55, 1, 0,  1, 1, 8'h22, 3, 1);
    // Backpressure on a full pipe for five cycles.
    for (int k = 0; k < 5; k++) add(1, 8'h66, 0, 0,  1, 1, 8'h33, 3, 0);
    add(1, 8'h66, 1, 0,  1, 1, 8'h33, 3, 1);
    add(0, 8'h00, 1, 0,  1, 1, 8'h44, 3, 1);
    add(0, 8'h00, 1, 0,  1, 1, 8'h55, 2, 1);
    add(0, 8'h00, 1, 0,  1, 1, 8'h66, 1, 1);
    add(0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1);
    // Bubble collapse: one beat drifts to the last stage under backpressure.
    add(1, 8'h77, 0, 0,  0, 0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0,  0, 0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0,  1, 1, 8'h77, 1, 1);
    add(0, 8'h00, 0, 0,  1, 1, 8'h77, 1, 1);
    add(0, 8'h00, 1, 0,  1, 1, 8'h77, 1, 1);
    add(0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1);
    // Flush of a full pipe with a new beat offered in the flush cycle.
    add(1, 8'hA1, 0, 0,  0, 0, 8'h00, 0, 1);
    add(1, 8'hA2, 0, 0,  0, 0, 8'h00, 1, 1);
    add(1, 8'hA3, 0, 0,  0, 0, 8'h00, 2, 1);
    add(0, 8'h00, 0, 0,  1, 1, 8'hA1, 3, 0);
    add(1, 8'hB0, 0, 1,  1, 1, 8'hA1, 3, 1);
    add(0, 8'h00, 0, 0,  0, 1, 8'hA1, 0, 1);
    add(0, 8'h00, 1, 0,  0, 1, 8'hA1, 0, 1);
    add(0, 8'h00, 1, 0,  0, 1, 8'hA1, 0, 1);

    repeat (2) @(negedge clk_i);
    #1;
    check_reset("in_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_reset("post_reset");

    foreach (vecs[k]) begin
      @(negedge clk_i);
      valid_i = vecs[k].vi;
      data_i  = vecs[k].d;
      ready_i = vecs[k].ri;
      flush_i = vecs[k].fl;
      #1;
      check($sformatf("vec%0d valid_o", k), valid_o, vecs[k].evo);
      check($sformatf("vec%0d ready_o", k), ready_o, vecs[k].ero);
      check($sformatf("vec%0d occupancy_o", k), occupancy_o, vecs[k].eocc);
      check($sformatf("vec%0d id_error_o", k), id_error_o, 0);
      if (vecs[k].chkd) check($sformatf("vec%0d data_o", k), data_o, vecs[k].ed);
    end

    // ID checker disabled: arbitrary IDs raise nothing.
    ready_i  = 1'b1;
    enable_i = 1'b0;
    send(1, 8'h01); send(2, 8'h02); send(3, 8'h03);
    idle(5);
    check("disabled no error", err_pulses, 0);
    e0 = err_pulses;

    enable_i = 1'b1;
    send(5, 8'h10); send(5, 8'h11); send(5, 8'h12);
    send(7, 8'h13); send(7, 8'h14); send(7, 8'h15);
    idle(5);
    check("clean triplets", err_pulses, e0);

    send(5, 8'h20); send(5, 8'h21); send(9, 8'h22); send(9, 8'h23); send(9, 8'h24);
    idle(5);
    check("broken triplet pulses", err_pulses, e0 + 1);
    check("id9 handshake seen", (hs9_cyc >= 0), 1);
    check("error pulse timing", err_cyc, hs9_cyc + 1);

    // A lone copy followed by a flush must not leave a stale count behind.
    send(4, 8'h30);
    idle(5);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    send(6, 8'h31); send(6, 8'h32); send(6, 8'h33);
    idle(5);
    check("flush clears count", err_pulses, e0 + 1);
    enable_i = 1'b0;

    // Reset with two beats in flight, first one already at the output.
    ready_i = 1'b0;
    send(1, 8'hC1); send(2, 8'hC2);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("pre_reset valid_o", valid_o, 1);
    check("pre_reset data_o", data_o, 8'hC1);
    check("pre_reset occupancy_o", occupancy_o, 2);
    #1;
    rst_i = 1'b1;
    #1;
    check_reset("mid_reset");
    @(negedge clk_i);
    rst_i   = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'hC3;
    id_i    = 5'd3;
    ready_i = 1'b1;
    #1;
    check_reset("after_mid_reset");
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    check("rst lat1 valid_o", valid_o, 0);
    @(negedge clk_i);
    #1;
    check("rst lat2 valid_o", valid_o, 0);
    @(negedge clk_i);
    #1;
    check("rst lat3 valid_o", valid_o, 1);
    check("rst lat3 data_o", data_o, 8'hC3);
    check("rst lat3 id_o", id_o, 5'd3);
    @(negedge clk_i);
    #1;
    check("rst drained valid_o", valid_o, 0);
    check("rst drained occupancy_o", occupancy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
